zap_copro_dispatch: RTL and testbench
=====================================

# zap_copro_dispatch

Sequences the core's single coprocessor request channel (dav plus 32-bit instruction word, held until done) onto up to 16 coprocessor slots, selected by the instruction's coprocessor-number field [11:8]. It sits between the decode-stage coprocessor interface and the attached coprocessors (e.g. CP15), and returns a single done pulse to the decode stage. It also generates an undefined-instruction response for absent or unresponsive coprocessors and aborts cleanly on pipeline flush.

## Interface
- `CP_PRESENT`, default 16'h8000: bit n=1 means coprocessor n is attached.
- `TIMEOUT`, default 256: maximum cycles a request may wait in WAIT for `i_cp_done`; range 2..65535.
- `i_clk`, in, 1: core clock. One clock domain.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_clear`, in, 1: pipeline flush (writeback or ALU clear); synchronous abort.
- `i_copro_dav`, in, 1: request valid from decode. Held high until after `o_copro_done`.
- `i_copro_word`, in, 32: coprocessor instruction. Stable while `i_copro_dav` is high.
- `o_copro_done`, out, 1: one-cycle completion pulse to decode.
- `o_copro_undef`, out, 1: qualifies `o_copro_done`; 1 means take the undefined-instruction trap.
- `o_cp_dav`, out, 16: one-hot request to coprocessor slot n.
- `o_cp_word`, out, 32: latched instruction broadcast to all slots.
- `i_cp_done`, in, 16: per-slot completion. Only the selected bit is observed.

## Operation
All outputs are registered. Reset value of every output is 0; state resets to IDLE and the counter to 0.

States:
- **IDLE**
  - Outputs are 0.
  - On `i_copro_dav`=1: latch `i_copro_word` into `o_cp_word` and set sel = word[11:8].
  - If `CP_PRESENT[sel]`=1: go to WAIT, assert `o_cp_dav[sel]`, clear the counter.
  - If `CP_PRESENT[sel]`=0: go to RESP with undef=1. No slot is ever driven.
- **WAIT**
  - `o_cp_dav[sel]` and `o_cp_word` are held stable.
  - On `i_cp_done[sel]`=1: drop `o_cp_dav` and go to RESP with undef=0.
  - Else, if counter = `TIMEOUT`-1: drop `o_cp_dav` and go to RESP with undef=1.
  - Else: increment the counter.
  - If done and timeout occur in the same cycle, done wins (undef=0).
- **RESP**
  - `o_copro_done`=1 for exactly one cycle; `o_copro_undef`=undef flag.
  - Then go to RELEASE.
- **RELEASE**
  - Ignore `i_copro_dav` while it is still high, so the same request is never re-launched.
  - Go to IDLE on the first cycle `i_copro_dav`=0.

Rules:
- `i_clear` has priority over every transition. Next state is IDLE, `o_cp_dav`=0, and no done pulse is issued, including when RESP was pending. The counter is cleared.
- `i_cp_done` bits of non-selected slots are ignored in every state. `i_cp_done` seen in IDLE, RESP or RELEASE is ignored.
- Asynchronous reset mid-request drops `o_cp_dav` immediately. The coprocessor must treat a dav fall without done as an abort.
- `o_cp_word` holds its last value outside WAIT. It is not cleared except by reset.

## Timing
- Present coprocessor: `i_copro_dav` sampled at edge 0 → `o_cp_dav[sel]` high from cycle 1. `i_cp_done[sel]` sampled at edge k → `o_copro_done` high in cycle k+1 and `o_cp_dav` low in cycle k+1.
- Absent coprocessor: `o_copro_done`=`o_copro_undef`=1 in cycle 1 (latency 1).
- Timeout: `o_cp_dav` is high for exactly `TIMEOUT` cycles, then done+undef follow in the next cycle.
- Minimum request-to-request spacing: IDLE → WAIT → RESP → RELEASE → IDLE, i.e. 4 cycles when the coprocessor answers in its first WAIT cycle.
- Counter width is clog2(`TIMEOUT`). It never wraps because the timeout compare fires first.

## Structure
- Shared package/header (alongside the existing ZAP defines and localparams):
  - state encoding localparams IDLE/WAIT/RESP/RELEASE
  - coprocessor-number field position [11:8]
  - CP15 index constant
- Single module; no sub-module. The counter is inline.
- `CP_PRESENT` is parameter-only, with no runtime configuration.

## Test plan
1. Reset with `i_copro_dav`=1 asserted → all outputs 0. After release, word 32'hEE110F10 (MRC p15) gives `o_cp_dav`=16'h8000 in cycle 1 and `o_cp_word`=32'hEE110F10.
2. CP15 asserts `i_cp_done[15]` on its 3rd WAIT cycle → `o_copro_done`=1 and `o_copro_undef`=0 for one cycle. With `i_copro_dav` held 2 more cycles, no second launch occurs.
3. Word targeting p7 with `CP_PRESENT`=16'h8000 → `o_copro_done`=1 and `o_copro_undef`=1 in cycle 1; `o_cp_dav` stays 0 throughout.
4. `TIMEOUT`=4 and CP15 never answers → `o_cp_dav[15]` high for exactly 4 cycles, then done+undef pulse.
5. Done and timeout coincide on the last WAIT cycle → undef=0. Also: `i_cp_done[3]` while sel=15 is ignored.
6. `i_clear` during WAIT and, separately, during RESP → IDLE next cycle, `o_cp_dav`=0, no `o_copro_done` pulse. A new request afterwards is accepted normally.

Source files
------------

// File: rtl/zap_copro_dispatch_pkg.sv
// zap_copro_dispatch_pkg
// Shared definitions for the coprocessor dispatch block: state encoding,
// the position of the coprocessor-number field inside a coprocessor
// instruction word, and the CP15 slot index.
package zap_copro_dispatch_pkg;

  // State encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    WAIT    = ST_WAIT,
    RESP    = ST_RESP,
    RELEASE = ST_RELEASE
  } cp_state_t;

  // Coprocessor-number field of a coprocessor instruction
  localparam int CP_NUM_LSB = 8;
  localparam int CP_NUM_MSB = 11;

  // System control coprocessor slot
  localparam logic [3:0] CP15_IDX = 4'd15;

  // Extract the target coprocessor number from an instruction word
  function automatic logic [3:0] cp_num(input logic [31:0] word);
    return word[CP_NUM_MSB:CP_NUM_LSB];
  endfunction

endpackage

// File: rtl/zap_copro_dispatch.sv
// zap_copro_dispatch
// Routes the decode stage's single coprocessor request onto one of 16
// coprocessor slots, selected by the coprocessor-number field of the
// instruction. Absent or unresponsive coprocessors produce an
// undefined-instruction response; a pipeline flush aborts cleanly.
//
// Ports:
//   i_clk          core clock
//   i_reset        asynchronous active-high reset
//   i_clear        synchronous pipeline flush, overrides every transition
//   i_copro_dav    request valid from decode, held until after done
//   i_copro_word   coprocessor instruction, stable while dav is high
//   o_copro_done   one-cycle completion pulse to decode
//   o_copro_undef  qualifies done: take the undefined-instruction trap
//   o_cp_dav       one-hot request to the selected coprocessor slot
//   o_cp_word      latched instruction broadcast to all slots
//   i_cp_done      per-slot completion, only the selected bit matters
module zap_copro_dispatch
  import zap_copro_dispatch_pkg::*;
#(
  parameter logic [15:0] CP_PRESENT = 16'd1 << CP15_IDX,
  parameter int          TIMEOUT    = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_copro_dav,
  input  logic [31:0] i_copro_word,
  output logic        o_copro_done,
  output logic        o_copro_undef,
  output logic [15:0] o_cp_dav,
  output logic [31:0] o_cp_word,
  input  logic [15:0] i_cp_done
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  cp_state_t        state;
  logic [3:0]       sel;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       req_num;

  assign req_num = cp_num(i_copro_word);

  // Main sequencer. The done pulse is raised on the transition into RESP
  // so that it is visible during the RESP cycle itself; a flush that
  // arrives on that transition therefore suppresses the pulse entirely.
  // RELEASE waits for decode to drop dav so a held request is never
  // launched a second time.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      sel           <= '0;
      cnt           <= '0;
      o_copro_done  <= 1'b0;
      o_copro_undef <= 1'b0;
      o_cp_dav      <= '0;
      o_cp_word     <= '0;
    end else begin
      o_copro_done  <= 1'b0;
      o_copro_undef <= 1'b0;

      if (i_clear) begin
        state    <= IDLE;
        o_cp_dav <= '0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_copro_dav) begin
              o_cp_word <= i_copro_word;
              sel       <= req_num;
              if (CP_PRESENT[req_num]) begin
                o_cp_dav <= 16'd1 << req_num;
                cnt      <= '0;
                state    <= WAIT;
              end else begin
                o_copro_done  <= 1'b1;
                o_copro_undef <= 1'b1;
                state         <= RESP;
              end
            end
          end

          // A completion on the final counted cycle still wins over the
          // timeout, so done is checked first.
          WAIT: begin
            if (i_cp_done[sel]) begin
              o_cp_dav     <= '0;
              o_copro_done <= 1'b1;
              state        <= RESP;
            end else if (cnt == CNT_LAST) begin
              o_cp_dav      <= '0;
              o_copro_done  <= 1'b1;
              o_copro_undef <= 1'b1;
              state         <= RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RESP: begin
            state <= RELEASE;
          end

          RELEASE: begin
            if (!i_copro_dav) begin
              state <= IDLE;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zap_copro_dispatch.sv
// tb_zap_copro_dispatch
// Directed bench for zap_copro_dispatch with CP_PRESENT = 16'h8000 and a
// short TIMEOUT of 4. Inputs change and outputs are sampled 1 time unit
// after each rising edge, so "cycle n" below is the cycle after edge n-1.
module tb_zap_copro_dispatch;

  logic        i_clk;
  logic        i_reset;
  logic        i_clear;
  logic        i_copro_dav;
  logic [31:0] i_copro_word;
  logic        o_copro_done;
  logic        o_copro_undef;
  logic [15:0] o_cp_dav;
  logic [31:0] o_cp_word;
  logic [15:0] i_cp_done;

  int vectors;
  int miscompares;

  localparam logic [31:0] MRC_P15 = 32'hEE110F10;
  localparam logic [31:0] MRC_P7  = 32'hEE110710;

  zap_copro_dispatch #(
    .CP_PRESENT(16'h8000),
    .TIMEOUT   (4)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_clear),
    .i_copro_dav  (i_copro_dav),
    .i_copro_word (i_copro_word),
    .o_copro_done (o_copro_done),
    .o_copro_undef(o_copro_undef),
    .o_cp_dav     (o_cp_dav),
    .o_cp_word    (o_cp_word),
    .i_cp_done    (i_cp_done)
  );

  // 10-unit core clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic applyStimulus(input logic dav, input logic [31:0] word,
                               input logic [15:0] cpdone, input logic clear);
    i_copro_dav  = dav;
    i_copro_word = word;
    i_cp_done    = cpdone;
    i_clear      = clear;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] exp_dav,
                             input logic exp_done, input logic exp_undef);
    checkVal({tag, ".cp_dav"}, {16'h0, o_cp_dav}, {16'h0, exp_dav});
    checkVal({tag, ".done"}, {31'h0, o_copro_done}, {31'h0, exp_done});
    checkVal({tag, ".undef"}, {31'h0, o_copro_undef}, {31'h0, exp_undef});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset asserted while decode already presents a p15 request
    i_reset = 1'b1;
    applyStimulus(1'b1, MRC_P15, 16'h0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset", 16'h0, 1'b0, 1'b0);
    checkVal("reset.word", o_cp_word, 32'h0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // MRC p15 launches in cycle 1
    tick();
    checkOutput("p15.c1", 16'h8000, 1'b0, 1'b0);
    checkVal("p15.c1.word", o_cp_word, MRC_P15);
    tick();
    checkOutput("p15.c2", 16'h8000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MRC_P15, 16'h8000, 1'b0);
    checkOutput("p15.c3", 16'h8000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MRC_P15, 16'h0, 1'b0);
    checkOutput("p15.resp", 16'h0, 1'b1, 1'b0);
    tick();
    checkOutput("p15.hold1", 16'h0, 1'b0, 1'b0);
    tick();
    checkOutput("p15.hold2", 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, MRC_P15, 16'h0, 1'b0);
    tick();
    checkOutput("p15.idle", 16'h0, 1'b0, 1'b0);

    // Absent coprocessor p7: undef response with latency 1, no slot driven
    applyStimulus(1'b1, MRC_P7, 16'h0, 1'b0);
    tick();
    checkOutput("p7.resp", 16'h0, 1'b1, 1'b1);
    checkVal("p7.word", o_cp_word, MRC_P7);
    tick();
    checkOutput("p7.release", 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, MRC_P7, 16'h0, 1'b0);
    tick();
    checkOutput("p7.idle", 16'h0, 1'b0, 1'b0);

    // Timeout: dav high for exactly 4 cycles, then done+undef
    applyStimulus(1'b1, MRC_P15, 16'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("tmo.c%0d", c), 16'h8000, 1'b0, 1'b0);
    end
    tick();
    checkOutput("tmo.resp", 16'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, MRC_P15, 16'h0, 1'b0);
    tick();
    checkOutput("tmo.release", 16'h0, 1'b0, 1'b0);
    tick();

    // Done coinciding with timeout wins; a done on slot 3 is ignored
    applyStimulus(1'b1, MRC_P15, 16'h0008, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput($sformatf("coin.c%0d", c), 16'h8000, 1'b0, 1'b0);
    end
    tick();
    applyStimulus(1'b1, MRC_P15, 16'h8008, 1'b0);
    checkOutput("coin.c4", 16'h8000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, MRC_P15, 16'h0, 1'b0);
    checkOutput("coin.resp", 16'h0, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("coin.idle", 16'h0, 1'b0, 1'b0);

    // Flush during WAIT, then the still-held request is accepted anew
    applyStimulus(1'b1, MRC_P15, 16'h0, 1'b0);
    tick();
    checkOutput("clrw.c1", 16'h8000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MRC_P15, 16'h0, 1'b1);
    tick();
    applyStimulus(1'b1, MRC_P15, 16'h0, 1'b0);
    checkOutput("clrw.flushed", 16'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, MRC_P15, 16'h8000, 1'b0);
    checkOutput("clrw.relaunch", 16'h8000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, MRC_P15, 16'h0, 1'b0);
    checkOutput("clrw.resp", 16'h0, 1'b1, 1'b0);
    tick();
    tick();

    // Flush on the same edge that would enter RESP: no done pulse at all
    applyStimulus(1'b1, MRC_P15, 16'h0, 1'b0);
    tick();
    applyStimulus(1'b1, MRC_P15, 16'h8000, 1'b1);
    checkOutput("clrr.c1", 16'h8000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, MRC_P15, 16'h0, 1'b0);
    checkOutput("clrr.flushed", 16'h0, 1'b0, 1'b0);
    tick();
    checkOutput("clrr.after", 16'h0, 1'b0, 1'b0);

    // Flush against an absent-coprocessor request, then normal acceptance
    applyStimulus(1'b1, MRC_P7, 16'h0, 1'b1);
    tick();
    applyStimulus(1'b1, MRC_P7, 16'h0, 1'b0);
    checkOutput("clra.flushed", 16'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, MRC_P7, 16'h0, 1'b0);
    checkOutput("clra.resp", 16'h0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("clra.idle", 16'h0, 1'b0, 1'b0);
    checkVal("clra.word", o_cp_word, MRC_P7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
